// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - ADXL345 register map, init/read tables and sequencer types
package accel_pkg;

   localparam int IDX_W = 3;

   localparam logic [7:0] REG_BW_RATE     = 8'h2C;
   localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
   localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
   localparam logic [7:0] REG_DATAX0      = 8'h32;

   localparam logic [IDX_W-1:0] INIT_LAST = 3'd2;
   localparam logic [IDX_W-1:0] READ_LAST = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_READ,
      ST_PUBLISH,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_ACCEPT,
      PH_BUSY
   } phase_t;

   // Init order: full-res +-16 g, 100 Hz output rate, then measure mode.
   function automatic logic [7:0] init_reg(input logic [IDX_W-1:0] i);
      case (i)
         3'd0:    return REG_DATA_FORMAT;
         3'd1:    return REG_BW_RATE;
         default: return REG_POWER_CTL;
      endcase
   endfunction

   function automatic logic [7:0] init_data(input logic [IDX_W-1:0] i);
      case (i)
         3'd0:    return 8'h0B;
         3'd1:    return 8'h0A;
         default: return 8'h08;
      endcase
   endfunction

   function automatic logic [7:0] read_reg(input logic [IDX_W-1:0] i);
      return REG_DATAX0 + 8'(i);
   endfunction

endpackage

// File: rtl/i2c_txn_port.sv
// rtl/i2c_txn_port.sv - one master transaction: start/busy handshake, timeout and read-byte capture
module i2c_txn_port
   import accel_pkg::*;
#(
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       req,
   input  logic       wr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   input  logic       i2c_busy,
   input  logic       i2c_dv,
   input  logic [7:0] i2c_data_rx,
   output logic       i2c_start,
   output logic       i2c_write,
   output logic [1:0] i2c_num_bytes,
   output logic [7:0] i2c_register,
   output logic [7:0] i2c_data_tx,
   output logic       done,
   output logic       timeout,
   output logic       dv_seen,
   output logic [7:0] rx_byte
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   phase_t        phase, phase_nxt;
   logic [TW-1:0] tmo_cnt;
   logic          dv_d;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) phase <= PH_IDLE;
      else          phase <= phase_nxt;
   end

   // Completion wins over a timeout that lands in the same cycle.
   always_comb begin
      phase_nxt = phase;
      done      = 1'b0;
      timeout   = 1'b0;
      case (phase)
         PH_IDLE:   if (req) phase_nxt = PH_ACCEPT;
         PH_ACCEPT: begin
            if (tmo_hit) begin
               timeout   = 1'b1;
               phase_nxt = PH_IDLE;
            end else if (i2c_busy) begin
               phase_nxt = PH_BUSY;
            end
         end
         PH_BUSY: begin
            if (!i2c_busy) begin
               done      = 1'b1;
               phase_nxt = PH_IDLE;
            end else if (tmo_hit) begin
               timeout   = 1'b1;
               phase_nxt = PH_IDLE;
            end
         end
         default: phase_nxt = PH_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         i2c_start     <= 1'b0;
         i2c_write     <= 1'b0;
         i2c_num_bytes <= 2'd0;
         i2c_register  <= 8'h00;
         i2c_data_tx   <= 8'h00;
         tmo_cnt       <= '0;
         dv_d          <= 1'b0;
         dv_seen       <= 1'b0;
         rx_byte       <= 8'h00;
      end else begin
         dv_d <= i2c_dv;
         if (phase == PH_IDLE) begin
            if (req) begin
               i2c_start     <= 1'b1;
               i2c_write     <= wr;
               i2c_num_bytes <= wr ? 2'd0 : 2'd1;
               i2c_register  <= reg_addr;
               i2c_data_tx   <= wr_data;
               tmo_cnt       <= '0;
               dv_seen       <= 1'b0;
            end
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (phase == PH_ACCEPT && (i2c_busy || timeout)) i2c_start <= 1'b0;
            if (i2c_dv && !dv_d) begin
               rx_byte <= i2c_data_rx;
               dv_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/i2c_accel_poller.sv
// rtl/i2c_accel_poller.sv - ADXL345 init and periodic 3-axis poll sequencer for the I2C master
module i2c_accel_poller
   import accel_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h53,
   parameter int         SAMPLE_DIV  = 500000,
   parameter int         TIMEOUT_CYC = 200000
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Enable,
   output logic               I2C_Start,
   output logic               I2C_Write,
   output logic [1:0]         I2C_Num_Bytes,
   output logic [6:0]         I2C_Address,
   output logic [7:0]         I2C_Register,
   output logic [7:0]         I2C_Data_Tx,
   input  logic               I2C_Buff_Next,
   input  logic               I2C_DV,
   input  logic               I2C_Busy,
   input  logic [7:0]         I2C_Data_Rx,
   output logic signed [15:0] Accel_X,
   output logic signed [15:0] Accel_Y,
   output logic signed [15:0] Accel_Z,
   output logic               Sample_Valid,
   output logic               Init_Done,
   output logic               Error,
   output logic [7:0]         Error_Count
);
   localparam int DW = $clog2(SAMPLE_DIV);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [4:0][7:0]  shadow;
   logic [DW-1:0]    tick_cnt;
   logic             tick_pending;
   logic             req, wr;
   logic [7:0]       reg_sel, data_sel;
   logic             done, timeout, dv_seen;
   logic [7:0]       rx_byte;
   logic             buff_next_unused;

   assign buff_next_unused = I2C_Buff_Next;
   assign I2C_Address      = DEV_ADDR;

   i2c_txn_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_txn (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .req           (req),
      .wr            (wr),
      .reg_addr      (reg_sel),
      .wr_data       (data_sel),
      .i2c_busy      (I2C_Busy),
      .i2c_dv        (I2C_DV),
      .i2c_data_rx   (I2C_Data_Rx),
      .i2c_start     (I2C_Start),
      .i2c_write     (I2C_Write),
      .i2c_num_bytes (I2C_Num_Bytes),
      .i2c_register  (I2C_Register),
      .i2c_data_tx   (I2C_Data_Tx),
      .done          (done),
      .timeout       (timeout),
      .dv_seen       (dv_seen),
      .rx_byte       (rx_byte)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // A transaction always runs to completion; Enable is only honoured between transactions.
   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      wr        = 1'b0;
      reg_sel   = 8'h00;
      data_sel  = 8'h00;
      case (state)
         ST_IDLE: if (Enable && !I2C_Busy) state_nxt = ST_INIT;
         ST_INIT: begin
            req      = 1'b1;
            wr       = 1'b1;
            reg_sel  = init_reg(idx);
            data_sel = init_data(idx);
            if (timeout)                 state_nxt = ST_ERR;
            else if (done && !Enable)    state_nxt = ST_IDLE;
            else if (done && idx == INIT_LAST) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!Enable)           state_nxt = ST_IDLE;
            else if (tick_pending) state_nxt = ST_READ;
         end
         ST_READ: begin
            req     = 1'b1;
            reg_sel = read_reg(idx);
            if (timeout)                       state_nxt = ST_ERR;
            else if (done && !dv_seen)         state_nxt = ST_ERR;
            else if (done && !Enable)          state_nxt = ST_IDLE;
            else if (done && idx == READ_LAST) state_nxt = ST_PUBLISH;
         end
         ST_PUBLISH: state_nxt = ST_RUN;
         ST_ERR:     state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         idx          <= '0;
         shadow       <= '0;
         tick_cnt     <= '0;
         tick_pending <= 1'b0;
         Accel_X      <= '0;
         Accel_Y      <= '0;
         Accel_Z      <= '0;
         Sample_Valid <= 1'b0;
         Init_Done    <= 1'b0;
         Error        <= 1'b0;
         Error_Count  <= 8'h00;
      end else begin
         if (state == ST_IDLE || state == ST_RUN) idx <= '0;
         else if (done)                           idx <= idx + IDX_W'(1);

         if (state == ST_READ && done && idx != READ_LAST) shadow[idx] <= rx_byte;

         // The final byte is still in rx_byte on the completing cycle, so all axes load together.
         Sample_Valid <= (state_nxt == ST_PUBLISH);
         if (state_nxt == ST_PUBLISH) begin
            Accel_X <= {shadow[1], shadow[0]};
            Accel_Y <= {shadow[3], shadow[2]};
            Accel_Z <= {rx_byte, shadow[4]};
         end

         Error <= (state_nxt == ST_ERR);
         if (state_nxt == ST_ERR && Error_Count != 8'hFF) Error_Count <= Error_Count + 8'd1;

         if (state == ST_INIT && state_nxt == ST_RUN)              Init_Done <= 1'b1;
         else if (state_nxt == ST_IDLE || state_nxt == ST_ERR)     Init_Done <= 1'b0;

         // A wrap on the same cycle the pending tick is consumed re-arms it.
         if (!Init_Done) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
         end else begin
            if (state == ST_RUN && state_nxt == ST_READ) tick_pending <= 1'b0;
            if (tick_cnt == DW'(SAMPLE_DIV - 1)) begin
               tick_cnt     <= '0;
               tick_pending <= 1'b1;
            end else begin
               tick_cnt <= tick_cnt + DW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_accel_poller.sv
// tb/tb_i2c_accel_poller.sv - directed bench for i2c_accel_poller with a behavioural I2C master
module tb_i2c_accel_poller;
   localparam int SDIV = 2000;
   localparam int TMO  = 300;

   logic               Clk = 1'b0;
   logic               Reset_n, Enable;
   logic               I2C_Start, I2C_Write;
   logic [1:0]         I2C_Num_Bytes;
   logic [6:0]         I2C_Address;
   logic [7:0]         I2C_Register, I2C_Data_Tx;
   logic               buff_next;
   logic               I2C_DV, I2C_Busy;
   logic [7:0]         I2C_Data_Rx;
   logic signed [15:0] Accel_X, Accel_Y, Accel_Z;
   logic               Sample_Valid, Init_Done, Error;
   logic [7:0]         Error_Count;

   i2c_accel_poller #(.DEV_ADDR(7'h53), .SAMPLE_DIV(SDIV), .TIMEOUT_CYC(TMO)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable),
      .I2C_Start(I2C_Start), .I2C_Write(I2C_Write), .I2C_Num_Bytes(I2C_Num_Bytes),
      .I2C_Address(I2C_Address), .I2C_Register(I2C_Register), .I2C_Data_Tx(I2C_Data_Tx),
      .I2C_Buff_Next(buff_next), .I2C_DV(I2C_DV), .I2C_Busy(I2C_Busy), .I2C_Data_Rx(I2C_Data_Rx),
      .Accel_X(Accel_X), .Accel_Y(Accel_Y), .Accel_Z(Accel_Z),
      .Sample_Valid(Sample_Valid), .Init_Done(Init_Done), .Error(Error), .Error_Count(Error_Count)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction log kept by the master model
   logic [7:0] t_reg [64];
   logic [7:0] t_dat [64];
   logic       t_wr  [64];
   logic [1:0] t_nb  [64];
   int         t_start [64];
   int         t_fall  [64];
   int         n_txn = 0;
   int         hang_idx = -1;
   int         nodv_idx = -1;
   bit         hang_release = 1'b0;

   function automatic logic [7:0] slave_byte(input logic [7:0] r);
      case (r)
         8'h32:   return 8'h34;
         8'h33:   return 8'h12;
         8'h34:   return 8'hFE;
         8'h35:   return 8'hFF;
         8'h36:   return 8'h00;
         8'h37:   return 8'h01;
         default: return 8'hAA;
      endcase
   endfunction

   task automatic run_txn();
      int k;
      bit rd;
      k  = n_txn;
      rd = !I2C_Write;
      if (k < 64) begin
         t_reg[k] = I2C_Register; t_dat[k] = I2C_Data_Tx;
         t_wr[k]  = I2C_Write;    t_nb[k]  = I2C_Num_Bytes;
         t_start[k] = cyc;
      end
      n_txn++;
      repeat (4) @(posedge Clk);
      #1 I2C_Busy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         if (i == 20 && rd && k != nodv_idx) begin
            I2C_DV      = 1'b1;
            I2C_Data_Rx = slave_byte(I2C_Register);
         end
      end
      while (k == hang_idx && !hang_release) begin
         @(posedge Clk); #1;
      end
      I2C_Busy = 1'b0;
      I2C_DV   = 1'b0;
      if (k < 64) t_fall[k] = cyc;
   endtask

   initial begin
      I2C_Busy = 1'b0; I2C_DV = 1'b0; I2C_Data_Rx = 8'h00; buff_next = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if (I2C_Start && !I2C_Busy) run_txn();
      end
   end

   int  n_smp = 0, n_err = 0, smp_cyc = 0, err_cyc = 0, init_cyc = 0;
   bit  init_q = 1'b0;
   always @(negedge Clk) begin
      if (Sample_Valid) begin n_smp++; smp_cyc = cyc; end
      if (Error)        begin n_err++; err_cyc = cyc; end
      if (Init_Done && !init_q) init_cyc = cyc;
      init_q = Init_Done;
   end

   task automatic step();
      @(negedge Clk); #1;
   endtask

   task automatic wait_smp(input int n, input int budget, input string tag);
      int t = 0;
      while (n_smp < n && t < budget) begin step(); t++; end
      check_eq(tag, n_smp, n);
   endtask

   task automatic wait_err(input int n, input int budget, input string tag);
      int t = 0;
      while (n_err < n && t < budget) begin step(); t++; end
      check_eq(tag, n_err, n);
   endtask

   task automatic wait_init(input int budget, input string tag);
      int t = 0;
      while (!Init_Done && t < budget) begin step(); t++; end
      check_eq(tag, Init_Done, 1);
   endtask

   task automatic wait_txn(input int n, input int budget, input string tag);
      int t = 0;
      while (n_txn < n && t < budget) begin step(); t++; end
      check_eq(tag, n_txn, n);
   endtask

   task automatic check_init_seq(input int b, input string tag);
      logic [7:0] regs [3];
      logic [7:0] dats [3];
      regs = '{8'h31, 8'h2C, 8'h2D};
      dats = '{8'h0B, 8'h0A, 8'h08};
      for (int i = 0; i < 3; i++) begin
         check_eq({tag, "_reg"}, t_reg[b+i], regs[i]);
         check_eq({tag, "_dat"}, t_dat[b+i], dats[i]);
         check_eq({tag, "_wr"},  t_wr[b+i],  1);
         check_eq({tag, "_nb"},  t_nb[b+i],  0);
      end
   endtask

   int b, smp0, t_wait;

   initial begin
      Reset_n = 1'b0; Enable = 1'b0;
      repeat (3) step();
      check_eq("rst_start", I2C_Start, 0);
      check_eq("rst_addr", I2C_Address, 7'h53);
      check_eq("rst_init_done", Init_Done, 0);
      check_eq("rst_err_cnt", Error_Count, 0);
      check_eq("rst_valid", Sample_Valid, 0);
      check_eq("rst_accel_x", $unsigned(Accel_X), 0);

      // Init sequence
      Enable = 1'b1; Reset_n = 1'b1;
      wait_init(1000, "init_wait");
      check_eq("init_txn_cnt", n_txn, 3);
      check_init_seq(0, "init");
      check_eq("init_done_lat", init_cyc - t_fall[2], 1);

      // First two samples
      wait_smp(1, SDIV + 500, "smp1_wait");
      for (int i = 0; i < 6; i++) begin
         check_eq("rd_reg", t_reg[3+i], 8'h32 + i);
         check_eq("rd_nb", t_nb[3+i], 1);
      end
      check_eq("smp_x", $unsigned(Accel_X), 16'h1234);
      check_eq("smp_y", $unsigned(Accel_Y), 16'hFFFE);
      check_eq("smp_z", $unsigned(Accel_Z), 16'h0100);
      check_eq("smp_lat", smp_cyc - t_fall[8], 1);
      step();
      check_eq("smp_pulse_len", Sample_Valid, 0);
      wait_smp(2, SDIV + 500, "smp2_wait");
      check_eq("smp_period", t_start[9] - t_start[3], SDIV);
      check_eq("smp2_z", $unsigned(Accel_Z), 16'h0100);

      // Busy stuck high on the second read of the next sample
      hang_idx = n_txn + 1;
      wait_err(1, SDIV + 1000, "tmo_wait");
      check_eq("tmo_lat", err_cyc - t_start[hang_idx], TMO);
      check_eq("tmo_err_cnt", Error_Count, 1);
      check_eq("tmo_init_done", Init_Done, 0);
      step();
      check_eq("tmo_err_pulse", Error, 0);
      repeat (50) step();
      check_eq("tmo_no_start", n_txn, hang_idx + 1);
      hang_release = 1'b1;
      wait_init(1000, "reinit_wait");
      check_init_seq(hang_idx + 1, "reinit");
      check_eq("reinit_after_busy", t_start[hang_idx+1] > t_fall[hang_idx], 1);

      // Read that completes with no DV
      nodv_idx = n_txn;
      smp0 = n_smp;
      wait_err(2, SDIV + 1000, "nodv_wait");
      check_eq("nodv_reg", t_reg[nodv_idx], 8'h32);
      check_eq("nodv_lat", err_cyc - t_fall[nodv_idx], 1);
      check_eq("nodv_err_cnt", Error_Count, 2);
      check_eq("nodv_no_smp", n_smp, smp0);
      wait_init(1000, "reinit2_wait");

      // Enable dropped during read index 2
      b = n_txn;
      smp0 = n_smp;
      wait_txn(b + 3, SDIV + 500, "drop_wait");
      Enable = 1'b0;
      check_eq("drop_reg", t_reg[b+2], 8'h34);
      repeat (150) step();
      check_eq("drop_finished", t_fall[b+2] > t_start[b+2], 1);
      check_eq("drop_no_start", n_txn, b + 3);
      check_eq("drop_no_smp", n_smp, smp0);
      check_eq("drop_init_done", Init_Done, 0);
      check_eq("drop_err_cnt", Error_Count, 2);

      // Reset while the master is busy
      b = n_txn;
      Enable = 1'b1;
      t_wait = 0;
      while (!I2C_Busy && t_wait < 100) begin step(); t_wait++; end
      check_eq("rstb_busy", I2C_Busy, 1);
      Reset_n = 1'b0;
      #1;
      check_eq("rstb_write", I2C_Write, 0);
      check_eq("rstb_reg", I2C_Register, 0);
      check_eq("rstb_data", I2C_Data_Tx, 0);
      check_eq("rstb_err_cnt", Error_Count, 0);
      check_eq("rstb_init_done", Init_Done, 0);
      step();
      Reset_n = 1'b1;
      wait_init(1000, "rstb_init_wait");
      check_eq("rstb_txn_cnt", n_txn, b + 4);
      check_eq("rstb_wait_busy", t_start[b+1] > t_fall[b], 1);
      check_init_seq(b + 1, "rstb_init");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_accel_poller.md
# i2c_accel_poller

Transaction sequencer that sits directly upstream of the I2C master on the DE10-Lite and drives its command port. The block runs the on-board ADXL345 accelerometer. After reset or an error, it writes a fixed three-register init sequence. It then reads the six data registers (X, Y and Z) once per sample period and publishes one atomic 3-axis sample with a one-cycle valid strobe.

## Interface
- DEV_ADDR, 7'h53: 7-bit slave address placed on I2C_Address.
- SAMPLE_DIV, 500000: Clk cycles between sample starts (10 ms at 50 MHz); minimum 2.
- TIMEOUT_CYC, 200000: maximum Clk cycles per transaction, from Start assertion to Busy fall.
- Clk  in  1  system clock.
- Reset_n  in  1  reset; one clock; asynchronous, active-low.
- Enable  in  1  level; 1 = run, 0 = finish current transaction then idle.
- I2C_Start  out  1  transaction request to the master.
- I2C_Write  out  1  1 = write, 0 = read.
- I2C_Num_Bytes  out  2  always 0 for a write (meaning 1 byte); always 1 for a read (1 byte).
- I2C_Address  out  7  always DEV_ADDR.
- I2C_Register  out  8  slave register index.
- I2C_Data_Tx  out  8  write data.
- I2C_Buff_Next  in  1  ignored; writes are single-byte, so Data_Tx is held for the whole transaction.
- I2C_DV  in  1  master read-data-valid level; the rising edge marks Data_Rx valid.
- I2C_Busy  in  1  master busy.
- I2C_Data_Rx  in  8  read byte.
- Accel_X / Accel_Y / Accel_Z  out  16 each  signed samples, {DATAx1, DATAx0}.
- Sample_Valid  out  1  one-cycle pulse; all three axes update in the same cycle.
- Init_Done  out  1  high after the init sequence completes, until error, disable or reset.
- Error  out  1  one-cycle pulse on a timeout or a missing DV.
- Error_Count  out  8  saturating count of Error pulses; cleared only by reset.

## Operation
- Reset values:
  - All outputs 0; I2C_Address = DEV_ADDR.
  - State IDLE; tick counter 0; tick_pending 0.
- Init table, in order, as {reg, data}: {0x31, 0x0B} (full-res ±16 g), {0x2C, 0x0A} (100 Hz), {0x2D, 0x08} (measure).
- Read table, in order: 0x32, 0x33, 0x34, 0x35, 0x36, 0x37 into shadow bytes 0–5.
- State machine:
  - IDLE: go to INIT when Enable=1 and I2C_Busy=0. Index is cleared to 0.
  - INIT: issue write[index]. On completion, index+1; after index 2, set Init_Done and go to RUN.
  - RUN: if Enable=0, go to IDLE and clear Init_Done. Else if tick_pending, clear it, set index 0 and go to READ.
  - READ: issue read[index]. On completion, index+1; after index 5, go to PUBLISH.
  - PUBLISH: copy the shadow into Accel_X/Y/Z and pulse Sample_Valid for one cycle, then go to RUN.
  - ERR: pulse Error, Error_Count+1 (saturates at 255), clear Init_Done, then go to IDLE. IDLE then re-runs init if Enable is still 1.
- Transaction handshake (issue sub-phase):
  - Drive the command fields and assert I2C_Start.
  - Hold Start until I2C_Busy=1 is sampled (accept), then drop Start.
  - Wait for I2C_Busy=0 (complete).
  - Command fields stay stable from Start assertion to completion.
- Read capture:
  - Register I2C_DV once per Clk.
  - On DV=1 and DV_d=0 during the transaction, latch I2C_Data_Rx into shadow[index] and set dv_seen.
  - A read that completes with dv_seen=0 goes to ERR.
- Timeout: a counter restarts at each Start assertion. Reaching TIMEOUT_CYC before completion goes to ERR. I2C_Start drops on entry to ERR.
- Sample tick:
  - The divider counts 0..SAMPLE_DIV-1 while Init_Done=1 and holds 0 otherwise.
  - A wrap sets tick_pending.
  - A wrap while tick_pending is already set is merged; no backlog is kept.
- Enable falling mid-transaction: the transaction runs to completion (the master cannot abort). The block then goes to IDLE with no publish, and partial shadow data is discarded.
- Reset mid-transaction: the block returns to IDLE immediately. IDLE waits for I2C_Busy=0 before any new Start, which lets the un-reset master drain.

## Timing
- Start is asserted on the cycle after a state entry.
- Completion is detected on the first cycle Busy=0 after accept.
- Sample_Valid asserts exactly 1 cycle after the completion of read index 5.
- Accel_* are stable from Sample_Valid until the next Sample_Valid.
- Error asserts on the cycle after the timeout compare or the missing-DV detection.
- Completion and a tick wrap in the same cycle: the tick is recorded and nothing is lost.

## Structure
- Package accel_pkg holds:
  - ADXL345 register constants.
  - The init {reg, data} table and the read register table.
  - State enum and index widths.
- Sub-module i2c_txn_port: Start/Busy accept-complete handshake, timeout counter and DV edge capture. It takes a request plus command fields and returns done, timeout, dv_seen and rx_byte.
- The top level holds the sequencer FSM, shadow registers and tick divider.

## Test plan
- Bench uses a behavioural master: Busy rises 4 cycles after Start, stays high 40 cycles, and raises DV with Data_Rx on reads.
- Reset, Enable=1: exactly three writes, {0x31,0x0B}, {0x2C,0x0A}, {0x2D,0x08}, in order. Init_Done rises after the third Busy fall.
- Slave returns 0x34, 0x12, 0xFE, 0xFF, 0x00, 0x01 for 0x32–0x37: Sample_Valid pulses once with X=0x1234, Y=0xFFFE, Z=0x0100. Reads recur every SAMPLE_DIV cycles (SAMPLE_DIV=2000).
- Busy held high forever on the second read: Error pulses at TIMEOUT_CYC, Error_Count=1, Init_Done=0. Init re-runs after Busy is released.
- Read completes without DV: Error pulses and there is no Sample_Valid.
- Enable dropped during read index 2: that transaction finishes, the block enters IDLE with no further Start and no Sample_Valid, and Init_Done=0.
- Reset_n pulsed while Busy=1: outputs go to 0 immediately. No Start is issued until Busy=0, then init begins.
